if_prefetch_queue: RTL and testbench

Instruction fetch stage of the 5-stage pipeline, directly upstream of the IF/ID register. It owns the fetch PC and drives the instruction memory address. It buffers fetched instructions in a small in-order queue and presents them, with their PC+4, to IF/ID through a valid/stall handshake. Branch redirects from EX/MEM flush the queue and restart fetch at the target.

---
 rtl/if_prefetch_queue.sv | 133 +++++++++++++
 tb/tb_if_prefetch_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction fetch stage sitting directly upstream of the IF/ID register.
// Owns the fetch PC (driven out as the instruction memory address), pushes
// each fetched word together with its PC+4 into a small in-order queue, and
// presents the queue head to IF/ID through a valid/stall handshake. A taken
// branch from EX/MEM flushes the queue and restarts fetch at the target.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset
//
// Ports
//   clk_i            clock, rising-edge
//   rst_i            asynchronous active-low reset
//   start_i          fetch enable; low freezes fetch PC and pushes
//   imem_addr_o      instruction memory address (= fetch PC)
//   imem_instr_i     instruction word for imem_addr_o, same cycle
//   stall_i          IF/ID cannot accept this cycle
//   redirect_i       taken branch
//   redirect_addr_i  branch target
//   valid_o          head outputs hold a real queued instruction
//   inst_o           head instruction (0 when empty)
//   addr_o           head instruction's PC+4 (0 when empty)
//   count_o          occupied entries
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  output logic [31:0]                    imem_addr_o,
  input  logic [31:0]                    imem_instr_i,
  input  logic                           stall_i,
  input  logic                           redirect_i,
  input  logic [31:0]                    redirect_addr_i,
  output logic                           valid_o,
  output logic [31:0]                    inst_o,
  output logic [31:0]                    addr_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Queue storage: one {pc+4, instr} pair per entry. Not reset; the head
  // outputs are gated by the occupancy count so stale contents never leak.
  logic [31:0] pc4_mem   [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic [31:0]   fpc_reg,    fpc_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg,  count_next;

  logic          head_valid;
  logic          pop;
  logic          push;
  logic [31:0]   fpc_plus4;

  // Target is word aligned; the low two bits are intentionally dropped.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^redirect_addr_i[1:0];

  assign head_valid = (count_reg != '0);
  assign fpc_plus4  = fpc_reg + 32'd4;   // wraps modulo 2^32

  // Redirect kills both push and pop. A full queue may still accept a push
  // when the head leaves in the same cycle.
  assign pop  = head_valid & ~stall_i & ~redirect_i;
  assign push = start_i & ~redirect_i & ((count_reg < DEPTH_C) | pop);

  always_comb begin
    fpc_next    = fpc_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;

    if (redirect_i) begin
      fpc_next    = {redirect_addr_i[31:2], 2'b00};
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        fpc_next    = fpc_plus4;
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fpc_reg    <= RESET_PC;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      fpc_reg    <= fpc_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc4_mem[wr_ptr_reg]   <= fpc_plus4;
      instr_mem[wr_ptr_reg] <= imem_instr_i;
    end
  end

  // Head outputs come from storage and count only, so there is no
  // combinational path from stall_i, redirect_i or imem_instr_i.
  assign imem_addr_o = fpc_reg;
  assign valid_o     = head_valid;
  assign inst_o      = head_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign addr_o      = head_valid ? pc4_mem[rd_ptr_reg]   : 32'h0;
  assign count_o     = count_reg;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Directed bench for if_prefetch_queue. The instruction memory returns the
// address as the instruction word. A table of per-cycle input/expected-output
// records is applied in a loop (inputs driven after the falling edge, outputs
// checked at the next falling edge), followed by hand-written sequences for
// asynchronous reset and combinational-isolation of the head outputs.
// ---------------------------------------------------------------------------
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] addr_o;
  logic [2:0]  count_o;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .imem_addr_o     (imem_addr_o),
    .imem_instr_i    (imem_instr_i),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .valid_o         (valid_o),
    .inst_o          (inst_o),
    .addr_o          (addr_o),
    .count_o         (count_o)
  );

  // Instruction memory model: word at address A is A.
  assign imem_instr_i = imem_addr_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start;
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    logic [2:0]  e_count;
    logic [31:0] e_imem;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input logic st, input logic sl, input logic rd, input logic [31:0] ra,
                     input logic v, input logic [31:0] i, input logic [31:0] a,
                     input logic [2:0] c, input logic [31:0] m);
    vec_t t;
    t.start = st; t.stall = sl; t.redir = rd; t.raddr = ra;
    t.e_valid = v; t.e_inst = i; t.e_addr = a; t.e_count = c; t.e_imem = m;
    vecs.push_back(t);
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] a, input logic [2:0] c, input logic [31:0] m);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
    chk({tag, ".inst"},  inst_o, i);
    chk({tag, ".addr"},  addr_o, a);
    chk({tag, ".count"}, {29'd0, count_o}, {29'd0, c});
    chk({tag, ".imem"},  imem_addr_o, m);
  endtask

  initial begin
    //   st sl rd raddr          valid inst          addr          cnt imem
    // steady stream from reset
    add(1, 0, 0, 32'h0,         1, 32'h00,        32'h04,        1, 32'h04);
    add(1, 0, 0, 32'h0,         1, 32'h04,        32'h08,        1, 32'h08);
    add(1, 0, 0, 32'h0,         1, 32'h08,        32'h0C,        1, 32'h0C);
    // stall 6 cycles: fill to DEPTH, then freeze
    add(1, 1, 0, 32'h0,         1, 32'h08,        32'h0C,        2, 32'h10);
    add(1, 1, 0, 32'h0,         1, 32'h08,        32'h0C,        3, 32'h14);
    add(1, 1, 0, 32'h0,         1, 32'h08,        32'h0C,        4, 32'h18);
    add(1, 1, 0, 32'h0,         1, 32'h08,        32'h0C,        4, 32'h18);
    add(1, 1, 0, 32'h0,         1, 32'h08,        32'h0C,        4, 32'h18);
    add(1, 1, 0, 32'h0,         1, 32'h08,        32'h0C,        4, 32'h18);
    // release: full + pop accepts a push, count stays 4
    add(1, 0, 0, 32'h0,         1, 32'h0C,        32'h10,        4, 32'h1C);
    add(1, 0, 0, 32'h0,         1, 32'h10,        32'h14,        4, 32'h20);
    // fetch disabled: drain in order
    add(0, 0, 0, 32'h0,         1, 32'h14,        32'h18,        3, 32'h20);
    add(0, 0, 0, 32'h0,         1, 32'h18,        32'h1C,        2, 32'h20);
    add(0, 0, 0, 32'h0,         1, 32'h1C,        32'h20,        1, 32'h20);
    add(0, 0, 0, 32'h0,         0, 32'h00,        32'h00,        0, 32'h20);
    add(0, 0, 0, 32'h0,         0, 32'h00,        32'h00,        0, 32'h20);
    // refill under stall
    add(1, 1, 0, 32'h0,         1, 32'h20,        32'h24,        1, 32'h24);
    add(1, 1, 0, 32'h0,         1, 32'h20,        32'h24,        2, 32'h28);
    add(1, 1, 0, 32'h0,         1, 32'h20,        32'h24,        3, 32'h2C);
    add(1, 1, 0, 32'h0,         1, 32'h20,        32'h24,        4, 32'h30);
    // redirect a full queue to 0x40
    add(1, 1, 1, 32'h40,        0, 32'h00,        32'h00,        0, 32'h40);
    add(1, 0, 0, 32'h0,         1, 32'h40,        32'h44,        1, 32'h44);
    // redirect with stall high and misaligned target
    add(1, 1, 1, 32'h43,        0, 32'h00,        32'h00,        0, 32'h40);
    add(1, 1, 0, 32'h0,         1, 32'h40,        32'h44,        1, 32'h44);
    // redirect to top of address space: PC+4 wraps
    add(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h00,        32'h00,        0, 32'hFFFF_FFFC);
    add(1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h00,        1, 32'h00);
    add(1, 0, 0, 32'h0,         1, 32'h00,        32'h04,        1, 32'h04);
    // redirect with fetch disabled still moves fpc, no push
    add(0, 0, 1, 32'h100,       0, 32'h00,        32'h00,        0, 32'h100);
    add(0, 0, 0, 32'h0,         0, 32'h00,        32'h00,        0, 32'h100);
    // refill three entries for the async reset sequence
    add(1, 1, 0, 32'h0,         1, 32'h100,       32'h104,       1, 32'h104);
    add(1, 1, 0, 32'h0,         1, 32'h100,       32'h104,       2, 32'h108);
    add(1, 1, 0, 32'h0,         1, 32'h100,       32'h104,       3, 32'h10C);

    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = 32'h0;
    #1 rst_i = 1'b0;
    #1;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 3'd0, RESET_PC);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      start_i = vecs[k].start; stall_i = vecs[k].stall;
      redirect_i = vecs[k].redir; redirect_addr_i = vecs[k].raddr;
      @(posedge clk_i);
      @(negedge clk_i);
      chk_all($sformatf("vec%0d", k), vecs[k].e_valid, vecs[k].e_inst,
              vecs[k].e_addr, vecs[k].e_count, vecs[k].e_imem);
      $display("vec %0d: st=%0b sl=%0b rd=%0b -> valid=%0b inst=%08h addr=%08h cnt=%0d imem=%08h",
               k, start_i, stall_i, redirect_i, valid_o, inst_o, addr_o, count_o, imem_addr_o);
    end

    // Head outputs must not react combinationally to stall_i/redirect_i.
    stall_i = 1'b0; redirect_i = 1'b1; redirect_addr_i = 32'h200;
    #1;
    chk("iso.valid", {31'd0, valid_o}, 32'd1);
    chk("iso.inst", inst_o, 32'h100);
    stall_i = 1'b1; redirect_i = 1'b0;
    #1;
    chk("iso.count", {29'd0, count_o}, 32'd3);
    $display("isolation: valid=%0b inst=%08h cnt=%0d", valid_o, inst_o, count_o);

    // Asynchronous reset mid-cycle with count 3: takes effect before any edge.
    #1 rst_i = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 32'h0, 3'd0, RESET_PC);
    $display("async reset: valid=%0b cnt=%0d imem=%08h", valid_o, count_o, imem_addr_o);
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1; stall_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk_all("post_rst", 1'b1, 32'h0, 32'h4, 3'd1, 32'h4);
    $display("post reset: valid=%0b inst=%08h addr=%08h cnt=%0d", valid_o, inst_o, addr_o, count_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
